// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus ID-stage hazard control for the RV32 pipeline:
// youngest-producer forwarding, load-use stall and a single-entry MUL/DIV scoreboard.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MD_LAT  = 4,
    parameter int SELW    = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_SRC-1:0]    ex_rs_addr,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_addr,
    input  logic [NUM_FWD-1:0]      fwd_we,
    output logic [SELW*NUM_SRC-1:0] fwd_sel,
    input  logic                    id_valid,
    input  logic [5*NUM_SRC-1:0]    id_rs_addr,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [4:0]              id_rd_addr,
    input  logic                    id_rd_we,
    input  logic                    id_is_md,
    input  logic                    ex_valid,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_rd_addr,
    input  logic                    ex_md_start,
    input  logic                    flush,
    output logic                    stall_id,
    output logic                    md_busy,
    output logic                    md_done,
    output logic [4:0]              md_rd_addr
);

    localparam int CNTW = $clog2(MD_LAT + 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t              state_r;
    md_state_t              state_s;
    logic [CNTW-1:0]        cnt_r;
    logic [CNTW-1:0]        cnt_s;
    logic [4:0]             md_rd_r;
    logic [4:0]             md_rd_s;
    logic                   done_r;
    logic                   done_s;
    logic [SELW*NUM_SRC-1:0] fwd_sel_s;
    logic                   load_use_s;
    logic                   md_dep_s;
    logic                   md_haz_s;
    logic                   stall_s;

    // True when any operand that is actually read names register rd.
    function automatic logic rs_hit(input logic [5*NUM_SRC-1:0] rs,
                                    input logic [NUM_SRC-1:0]   used,
                                    input logic [4:0]           rd);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit = hit | (used[i] & (rs[i*5 +: 5] == rd));
        end
        return hit;
    endfunction

    // Forwarding selects: walk oldest to youngest so the youngest match wins; x0 never matches.
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                fwd_sel_s[i*SELW +: SELW] =
                    (fwd_we[k] && (ex_rs_addr[i*5 +: 5] != 5'd0) &&
                     (fwd_rd_addr[k*5 +: 5] == ex_rs_addr[i*5 +: 5]))
                    ? SELW'(k + 1) : fwd_sel_s[i*SELW +: SELW];
            end
        end
    end

    // Scoreboard next state: count down MD_LAT cycles; a start while busy is ignored.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        md_rd_s = md_rd_r;
        case (state_r)
            MD_IDLE: begin
                if (ex_md_start) begin
                    state_s = MD_BUSY;
                    cnt_s   = CNTW'(MD_LAT);
                    md_rd_s = ex_rd_addr;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                cnt_s = cnt_r - CNTW'(1);
                if (cnt_r == CNTW'(1)) begin
                    state_s = MD_IDLE;
                end else begin
                    state_s = MD_BUSY;
                end
            end
            default: begin
                state_s = MD_IDLE;
                cnt_s   = '0;
            end
        endcase
        done_s = (state_s == MD_BUSY) && (cnt_s == CNTW'(1));
    end

    // Scoreboard registers; done is registered one cycle ahead so it lines up with cnt == 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MD_IDLE;
            cnt_r   <= '0;
            md_rd_r <= 5'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            md_rd_r <= md_rd_s;
            done_r  <= done_s;
        end
    end

    // Hazard terms; a flushed or empty ID slot never stalls.
    always_comb begin
        load_use_s = ex_valid && ex_is_load && (ex_rd_addr != 5'd0) &&
                     rs_hit(id_rs_addr, id_rs_used, ex_rd_addr);
        md_dep_s   = (md_rd_r != 5'd0) &&
                     (rs_hit(id_rs_addr, id_rs_used, md_rd_r) ||
                      (id_rd_we && (id_rd_addr == md_rd_r)));
        md_haz_s   = (state_r == MD_BUSY) && (md_dep_s || id_is_md);
        stall_s    = id_valid && !flush && (load_use_s || md_haz_s);
    end

    assign fwd_sel    = fwd_sel_s;
    assign stall_id   = stall_s;
    assign md_busy    = (state_r == MD_BUSY);
    assign md_done    = done_r;
    assign md_rd_addr = md_rd_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance (2 src, 2 fwd, lat 4) and a
// wide instance (3 src, 3 fwd, lat 2) driven side by side and checked via a queue.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       id_valid, id_rd_we, id_is_md, ex_valid, ex_is_load, ex_md_start, flush;
    logic [4:0] id_rd_addr, ex_rd_addr;
    logic [9:0] id_rs_a;
    logic [1:0] used_a;
    logic [14:0] id_rs_b;
    logic [2:0]  used_b;
    assign id_rs_b = {5'd0, id_rs_a};
    assign used_b  = {1'b0, used_a};

    logic [9:0]  ex_rs_a, fwd_rd_a;
    logic [1:0]  fwd_we_a;
    logic [3:0]  sel_a;
    logic [14:0] ex_rs_b, fwd_rd_b;
    logic [2:0]  fwd_we_b;
    logic [5:0]  sel_b;
    logic        stall_a, stall_b, busy_a, busy_b, done_a, done_b;
    logic [4:0]  mdrd_a, mdrd_b;

    fwd_hazard_unit dut_a (
        .clk(clk), .rst_n(rst_n), .ex_rs_addr(ex_rs_a), .fwd_rd_addr(fwd_rd_a),
        .fwd_we(fwd_we_a), .fwd_sel(sel_a), .id_valid(id_valid), .id_rs_addr(id_rs_a),
        .id_rs_used(used_a), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_md(id_is_md), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd_addr(ex_rd_addr), .ex_md_start(ex_md_start), .flush(flush),
        .stall_id(stall_a), .md_busy(busy_a), .md_done(done_a), .md_rd_addr(mdrd_a)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .NUM_FWD(3), .MD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_rs_addr(ex_rs_b), .fwd_rd_addr(fwd_rd_b),
        .fwd_we(fwd_we_b), .fwd_sel(sel_b), .id_valid(id_valid), .id_rs_addr(id_rs_b),
        .id_rs_used(used_b), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_md(id_is_md), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd_addr(ex_rd_addr), .ex_md_start(ex_md_start), .flush(flush),
        .stall_id(stall_b), .md_busy(busy_b), .md_done(done_b), .md_rd_addr(mdrd_b)
    );

    // Expected outputs; two-bit fields are {instance b, instance a}.
    typedef struct {
        string      name;
        logic [3:0] sel_a;
        logic [5:0] sel_b;
        logic [1:0] stall;
        logic [1:0] busy;
        logic [1:0] done;
        logic [4:0] rd_a;
        logic [4:0] rd_b;
    } exp_t;

    typedef struct {
        string       name;
        logic [9:0]  rs_a;
        logic [9:0]  rd_a;
        logic [1:0]  we_a;
        logic [14:0] rs_b;
        logic [14:0] rd_b;
        logic [2:0]  we_b;
        logic [3:0]  sel_a;
        logic [5:0]  sel_b;
    } fwd_vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(string n, logic [1:0] st, logic [1:0] bu, logic [1:0] dn,
                                logic [4:0] ra, logic [4:0] rb);
        exp_t e;
        e.name = n; e.sel_a = 4'd0; e.sel_b = 6'd0;
        e.stall = st; e.busy = bu; e.done = dn; e.rd_a = ra; e.rd_b = rb;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Push expectation at drive time, compare on the falling edge, return just after the next rising edge.
    task automatic apply(input exp_t e);
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk({x.name, ".sel_a"}, {28'd0, sel_a}, {28'd0, x.sel_a});
        chk({x.name, ".sel_b"}, {26'd0, sel_b}, {26'd0, x.sel_b});
        chk({x.name, ".stall"}, {30'd0, stall_b, stall_a}, {30'd0, x.stall});
        chk({x.name, ".busy"},  {30'd0, busy_b, busy_a},   {30'd0, x.busy});
        chk({x.name, ".done"},  {30'd0, done_b, done_a},   {30'd0, x.done});
        chk({x.name, ".rd_a"},  {27'd0, mdrd_a}, {27'd0, x.rd_a});
        chk({x.name, ".rd_b"},  {27'd0, mdrd_b}, {27'd0, x.rd_b});
        chk({x.name, ".start_while_busy"}, {31'd0, ex_md_start & (busy_a | busy_b)}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        fwd_vec_t tbl[6];
        exp_t     e;

        tbl[0] = '{"fwd_both_young", {5'd3,5'd5}, {5'd5,5'd5}, 2'b11,
                   {5'd0,5'd3,5'd5}, {5'd5,5'd5,5'd5}, 3'b111, {2'd0,2'd1}, {2'd0,2'd0,2'd1}};
        tbl[1] = '{"fwd_older_only", {5'd3,5'd5}, {5'd5,5'd5}, 2'b10,
                   {5'd0,5'd3,5'd5}, {5'd5,5'd5,5'd5}, 3'b110, {2'd0,2'd2}, {2'd0,2'd0,2'd2}};
        tbl[2] = '{"fwd_oldest",     {5'd3,5'd5}, {5'd5,5'd5}, 2'b00,
                   {5'd0,5'd3,5'd5}, {5'd5,5'd5,5'd5}, 3'b100, {2'd0,2'd0}, {2'd0,2'd0,2'd3}};
        tbl[3] = '{"fwd_x0",         10'd0, 10'd0, 2'b11,
                   15'd0, 15'd0, 3'b111, 4'd0, 6'd0};
        tbl[4] = '{"fwd_distinct",   {5'd7,5'd5}, {5'd7,5'd5}, 2'b11,
                   {5'd9,5'd7,5'd5}, {5'd9,5'd7,5'd5}, 3'b111, {2'd2,2'd1}, {2'd3,2'd2,2'd1}};
        tbl[5] = '{"fwd_mid_prio",   {5'd12,5'd12}, {5'd12,5'd12}, 2'b10,
                   {5'd12,5'd12,5'd12}, {5'd12,5'd12,5'd12}, 3'b110, {2'd2,2'd2}, {2'd2,2'd2,2'd2}};

        id_valid = 1'b0; id_rd_we = 1'b0; id_is_md = 1'b0; ex_valid = 1'b0;
        ex_is_load = 1'b0; ex_md_start = 1'b0; flush = 1'b0;
        id_rd_addr = 5'd0; ex_rd_addr = 5'd0; id_rs_a = 10'd0; used_a = 2'b00;
        ex_rs_a = 10'd0; fwd_rd_a = 10'd0; fwd_we_a = 2'b00;
        ex_rs_b = 15'd0; fwd_rd_b = 15'd0; fwd_we_b = 3'b000;

        apply(mk("reset", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            ex_rs_a = tbl[i].rs_a; fwd_rd_a = tbl[i].rd_a; fwd_we_a = tbl[i].we_a;
            ex_rs_b = tbl[i].rs_b; fwd_rd_b = tbl[i].rd_b; fwd_we_b = tbl[i].we_b;
            e = mk(tbl[i].name, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0);
            e.sel_a = tbl[i].sel_a;
            e.sel_b = tbl[i].sel_b;
            apply(e);
        end
        ex_rs_a = 10'd0; fwd_rd_a = 10'd0; fwd_we_a = 2'b00;
        ex_rs_b = 15'd0; fwd_rd_b = 15'd0; fwd_we_b = 3'b000;

        // Load-use
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_addr = 5'd7;
        id_valid = 1'b1; id_rs_a = {5'd7, 5'd1}; used_a = 2'b11;
        apply(mk("lu_stall", 2'b11, 2'b00, 2'b00, 5'd0, 5'd0));
        ex_is_load = 1'b0;
        apply(mk("lu_bubble", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        ex_is_load = 1'b1; used_a = 2'b01;
        apply(mk("lu_unused", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        used_a = 2'b11; flush = 1'b1;
        apply(mk("lu_flush", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        flush = 1'b0; ex_rd_addr = 5'd0; id_rs_a = 10'd0;
        apply(mk("lu_x0", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        ex_is_load = 1'b0;

        // MUL/DIV RAW on x9
        ex_rd_addr = 5'd9; ex_md_start = 1'b1; id_rs_a = {5'd9, 5'd1};
        apply(mk("raw_t0", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        ex_md_start = 1'b0; ex_rd_addr = 5'd3;
        apply(mk("raw_t1", 2'b11, 2'b11, 2'b00, 5'd9, 5'd9));
        apply(mk("raw_t2", 2'b11, 2'b11, 2'b10, 5'd9, 5'd9));
        apply(mk("raw_t3", 2'b01, 2'b01, 2'b00, 5'd9, 5'd9));
        apply(mk("raw_t4", 2'b01, 2'b01, 2'b01, 5'd9, 5'd9));
        apply(mk("raw_t5", 2'b00, 2'b00, 2'b00, 5'd9, 5'd9));

        // Structural and WAW
        id_rs_a = {5'd2, 5'd1}; ex_rd_addr = 5'd9; ex_md_start = 1'b1;
        apply(mk("sw_t0", 2'b00, 2'b00, 2'b00, 5'd9, 5'd9));
        ex_md_start = 1'b0; ex_rd_addr = 5'd3; id_is_md = 1'b1;
        apply(mk("sw_struct", 2'b11, 2'b11, 2'b00, 5'd9, 5'd9));
        id_is_md = 1'b0; id_rd_we = 1'b1; id_rd_addr = 5'd9;
        apply(mk("sw_waw", 2'b11, 2'b11, 2'b10, 5'd9, 5'd9));
        id_rd_addr = 5'd10;
        apply(mk("sw_nowaw_t3", 2'b00, 2'b01, 2'b00, 5'd9, 5'd9));
        apply(mk("sw_nowaw_t4", 2'b00, 2'b01, 2'b01, 5'd9, 5'd9));
        id_rd_we = 1'b0;
        apply(mk("sw_t5", 2'b00, 2'b00, 2'b00, 5'd9, 5'd9));

        // Reset in the middle of an operation
        id_rs_a = {5'd11, 5'd1}; ex_rd_addr = 5'd11; ex_md_start = 1'b1;
        apply(mk("rst_t0", 2'b00, 2'b00, 2'b00, 5'd9, 5'd9));
        ex_md_start = 1'b0; ex_rd_addr = 5'd3;
        apply(mk("rst_t1", 2'b11, 2'b11, 2'b00, 5'd11, 5'd11));
        rst_n = 1'b0; id_is_md = 1'b1;
        apply(mk("rst_async", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        rst_n = 1'b1; id_is_md = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(mk("rst_after", 2'b00, 2'b00, 2'b00, 5'd0, 5'd0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RV32 pipeline: generalises the two-stage, two-operand forwarding decision to NUM_SRC operands and NUM_FWD producer stages with youngest-producer priority and x0 exclusion. Adds sequential hazard control:
- a one-cycle load-use stall;
- a scoreboard and latency counter for a multi-cycle MUL/DIV unit, with RAW, WAW and structural stalls.

It sits beside the ID/EX boundary, drives EX operand mux selects and the ID/IF stall, and tracks one outstanding MUL/DIV operation.

## Interface
- NUM_SRC, 2: source operands per instruction (1..3).
- NUM_FWD, 2: forwarding producer stages; index 0 is youngest (EX/MEM), NUM_FWD-1 is oldest.
- MD_LAT, 4: MUL/DIV latency in cycles (2..32).
- SELW, $clog2(NUM_FWD+1): derived; width of one select field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_rs_addr  in  5*NUM_SRC  EX-stage source register numbers; operand i at [5i+4:5i].
- fwd_rd_addr  in  5*NUM_FWD  destination register of producer stage k.
- fwd_we  in  NUM_FWD  register-write enable of producer stage k.
- fwd_sel  out  SELW*NUM_SRC  per-operand select: 0 selects the register file; k+1 selects producer k.
- id_valid  in  1  ID holds a real instruction.
- id_rs_addr  in  5*NUM_SRC  ID source register numbers.
- id_rs_used  in  NUM_SRC  operand i is actually read.
- id_rd_addr  in  5  ID destination register.
- id_rd_we  in  1  ID writes a register.
- id_is_md  in  1  ID instruction is MUL/DIV.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd_addr  in  5  EX destination register.
- ex_md_start  in  1  EX issues a MUL/DIV this cycle.
- flush  in  1  taken branch/jump; the ID instruction is killed.
- stall_id  out  1  hold PC and IF/ID; inject a bubble into EX.
- md_busy  out  1  MUL/DIV operation outstanding.
- md_done  out  1  one-cycle pulse: MUL/DIV result written back this cycle.
- md_rd_addr  out  5  destination register of the outstanding MUL/DIV.

## Operation
- **Forwarding (combinational)**
  - For each operand i, fwd_sel_i = k+1 for the smallest k with fwd_we[k] and fwd_rd_addr_k == ex_rs_addr_i; otherwise 0.
  - Register 0 never matches, so its select is always 0.
- **Load-use hazard:** stall_id is asserted when ex_valid && ex_is_load && ex_rd_addr != 0 && id_valid and some used id_rs_i == ex_rd_addr.
- **Scoreboard**
  - State machine IDLE/BUSY with a counter cnt (width $clog2(MD_LAT+1)).
  - IDLE & ex_md_start: go to BUSY, load cnt = MD_LAT, latch md_rd_addr = ex_rd_addr.
  - BUSY: cnt decrements every cycle.
  - When cnt == 1 in BUSY, md_done is asserted that cycle and the next state is IDLE.
  - ex_md_start in BUSY is a protocol violation: ignored, with no state change. The bench asserts it never occurs.
- **MUL/DIV stalls while md_busy and md_rd_addr != 0**
  - RAW: some used id_rs_i == md_rd_addr.
  - WAW: id_rd_we && id_rd_addr == md_rd_addr.
  - Structural: id_is_md stalls while md_busy, regardless of md_rd_addr.
- stall_id is the OR of all hazard terms, gated by id_valid and by !flush. A flush forces stall_id = 0 in that cycle.
- flush does not cancel an outstanding MUL/DIV. The EX-stage operation is older than the branch.
- md_rd_addr holds its last value in IDLE.

## Timing
- Reset values:
  - State IDLE, cnt = 0, md_rd_addr = 0.
  - md_busy = 0, md_done = 0, stall_id = 0.
  - fwd_sel follows its inputs combinationally.
- fwd_sel and stall_id are combinational, with zero latency from their inputs.
- MUL/DIV cycle sequence for ex_md_start sampled at the edge ending cycle t:
  - md_busy is high in cycles t+1..t+MD_LAT.
  - md_done is high in cycle t+MD_LAT only.
  - Dependent stalls are held through t+MD_LAT and released in t+MD_LAT+1, after the register-file write.
- Load-use stall lasts exactly one cycle, because the load advances to MEM while the bubble enters EX.
- Reset asserted mid-operation: everything returns to IDLE immediately (asynchronously), with no md_done pulse.
- A producer match at several stages always selects the youngest stage. Equal rd at both k=0 and k=1 gives select 1.

## Test plan
- **Forwarding priority:** NUM_FWD=2, rs1=5, fwd_rd={5,5}, we={1,1} -> fwd_sel_0=1. Then we={0,1} -> 2. Then we={0,0} -> 0. Then rs1=0 with all rd=0 and we=1 -> 0.
- **Load-use:** ex_is_load with rd=7 and ID using rs2=7 -> stall_id=1 for one cycle. Same case with id_rs_used[1]=0 -> 0. Same case with flush=1 -> 0.
- **MUL/DIV RAW:** MD_LAT=4, start with rd=9 at t, and ID reads x9 -> md_busy in t+1..t+4, md_done at t+4, stall_id high t+1..t+4, stall_id low at t+5.
- **Structural and WAW:** while busy, id_is_md -> stall. While busy, id_rd=9 with we -> stall. While busy, id_rd=10 -> no stall.
- **Reset mid-op:** drop rst_n at t+2 -> md_busy, md_done and stall_id all 0 immediately. No md_done pulse after reset is released.
- **Parametrisation:** rerun the scenarios with NUM_SRC=3, NUM_FWD=3, MD_LAT=2 -> oldest-stage select is 3, and md_done occurs at t+2.
